// File: rtl/crypt_job_scheduler_pkg.sv
// Shared constants and types for the crypt job scheduler.
package crypt_sched_pkg;

  // State codes reported by the encode/decode controller FSM.
  localparam logic [2:0] FSM_IDLE  = 3'b000;
  localparam logic [2:0] FSM_LOAD1 = 3'b101;
  localparam logic [2:0] FSM_LOAD2 = 3'b110;
  localparam logic [2:0] FSM_KG1   = 3'b001;
  localparam logic [2:0] FSM_KG2   = 3'b010;
  localparam logic [2:0] FSM_ENC   = 3'b011;
  localparam logic [2:0] FSM_DEC   = 3'b100;

  // Job mode as seen on mode0/mode1 and fsm_encode.
  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT_START = 3'd2,
    S_RUN        = 3'd3,
    S_DONE       = 3'd4,
    S_ABORT      = 3'd5
  } sched_state_e;

  // True when the FSM sits in a final crypto state that contradicts the job mode.
  function automatic logic code_mismatch(input logic [2:0] code, input logic mode);
    return ((code == FSM_ENC) && (mode != MODE_ENC)) ||
           ((code == FSM_DEC) && (mode != MODE_DEC));
  endfunction

  // True for either final crypto state.
  function automatic logic code_final(input logic [2:0] code);
    return (code == FSM_ENC) || (code == FSM_DEC);
  endfunction

endpackage

// File: rtl/crypt_job_scheduler_if.sv
// Host-side request/response and FSM-side control signals of the scheduler.
interface crypt_job_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             req0;
  logic             req1;
  logic             mode0;
  logic             mode1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             err0;
  logic             err1;
  logic             fsm_enable;
  logic             fsm_encode;
  logic             fsm_restart;
  logic [2:0]       fsm_state;
  logic             busy;
  logic             owner;
  logic [CNT_W-1:0] job_count;

  // Scheduler side.
  modport slave (
    input  req0, req1, mode0, mode1, fsm_state,
    output gnt0, gnt1, done0, done1, err0, err1,
           fsm_enable, fsm_encode, fsm_restart,
           busy, owner, job_count
  );

  // Requester / FSM side.
  modport master (
    output req0, req1, mode0, mode1, fsm_state,
    input  gnt0, gnt1, done0, done1, err0, err1,
           fsm_enable, fsm_encode, fsm_restart,
           busy, owner, job_count
  );
endinterface

// File: rtl/crypt_job_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the port that did not own the
// last job wins; a lone request always wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] gnt_o
);

  // Pick a one-hot winner from the current requests.
  always_comb begin
    gnt_o = 2'b00;
    if (&req_i) begin
      gnt_o = last_owner_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/crypt_job_scheduler.sv
// Shares one encode/decode controller FSM between two requesters, launches
// each job, watches the FSM state codes and reports done/err per job.
//
// state        | meaning
// S_IDLE       | no job; arbitrate pending requests
// S_LAUNCH     | grant issued; pulse fsm_enable next
// S_WAIT_START | waiting for the FSM to leave IDLE (START_TO limit)
// S_RUN        | job running; track final state and mode (RUN_TO limit)
// S_DONE       | FSM back in IDLE; report done/err to the owner
// S_ABORT      | timeout; restart the FSM and report an error
module crypt_job_scheduler
  import crypt_sched_pkg::*;
#(
  parameter int START_TO = 4,
  parameter int RUN_TO   = 15,
  parameter int CNT_W    = 8
) (
  input  logic                  clka,
  input  logic                  restart_n,
  crypt_job_scheduler_if.slave  bus
);

  localparam int TMR_MAX = (START_TO > RUN_TO) ? START_TO : RUN_TO;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  sched_state_e     state_q, state_d;
  logic             owner_q, owner_d;
  logic             enc_q, enc_d;
  logic             busy_q, busy_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             seen_final_q, seen_final_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             enable_q, enable_d;
  logic             restart_q, restart_d;

  logic [1:0]       arb_gnt;

  rr_arbiter2 u_arb (
    .req_i        ({bus.req1, bus.req0}),
    .last_owner_i (owner_q),
    .gnt_o        (arb_gnt)
  );

  // Next-state logic for the job sequencer, timer, flags and output pulses.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    enc_d        = enc_q;
    busy_d       = busy_q;
    timer_d      = timer_q;
    seen_final_d = seen_final_q;
    mismatch_d   = mismatch_q;
    count_d      = count_q;
    gnt_d        = 2'b00;
    done_d       = 2'b00;
    err_d        = 2'b00;
    enable_d     = 1'b0;
    restart_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|arb_gnt) begin
          gnt_d   = arb_gnt;
          owner_d = arb_gnt[1];
          enc_d   = arb_gnt[1] ? bus.mode1 : bus.mode0;
          busy_d  = 1'b1;
          state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        enable_d     = 1'b1;
        timer_d      = '0;
        seen_final_d = 1'b0;
        mismatch_d   = 1'b0;
        state_d      = S_WAIT_START;
      end

      S_WAIT_START: begin
        if (bus.fsm_state != FSM_IDLE) begin
          timer_d = '0;
          state_d = S_RUN;
        end else if (timer_q == TMR_W'(START_TO - 1)) begin
          state_d = S_ABORT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_RUN: begin
        if (bus.fsm_state == FSM_IDLE) begin
          // A job that never reached ENC/DEC did not produce a result.
          mismatch_d = mismatch_q | ~seen_final_q;
          state_d    = S_DONE;
        end else begin
          if (code_final(bus.fsm_state)) begin
            seen_final_d = 1'b1;
          end
          if (code_mismatch(bus.fsm_state, enc_q)) begin
            mismatch_d = 1'b1;
          end
          if (timer_q == TMR_W'(RUN_TO - 1)) begin
            state_d = S_ABORT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        done_d[owner_q] = 1'b1;
        err_d[owner_q]  = mismatch_q;
        if (!mismatch_q) begin
          count_d = count_q + 1'b1;
        end
        busy_d  = 1'b0;
        enc_d   = 1'b0;
        state_d = S_IDLE;
      end

      S_ABORT: begin
        restart_d       = 1'b1;
        done_d[owner_q] = 1'b1;
        err_d[owner_q]  = 1'b1;
        busy_d          = 1'b0;
        enc_d           = 1'b0;
        state_d         = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset holds the FSM in restart and drops any job.
  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b1;
      enc_q        <= 1'b0;
      busy_q       <= 1'b0;
      timer_q      <= '0;
      seen_final_q <= 1'b0;
      mismatch_q   <= 1'b0;
      count_q      <= '0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      enable_q     <= 1'b0;
      restart_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      enc_q        <= enc_d;
      busy_q       <= busy_d;
      timer_q      <= timer_d;
      seen_final_q <= seen_final_d;
      mismatch_q   <= mismatch_d;
      count_q      <= count_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      enable_q     <= enable_d;
      restart_q    <= restart_d;
    end
  end

  assign bus.gnt0        = gnt_q[0];
  assign bus.gnt1        = gnt_q[1];
  assign bus.done0       = done_q[0];
  assign bus.done1       = done_q[1];
  assign bus.err0        = err_q[0];
  assign bus.err1        = err_q[1];
  assign bus.fsm_enable  = enable_q;
  assign bus.fsm_encode  = enc_q;
  assign bus.fsm_restart = restart_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign bus.job_count   = count_q;

endmodule

// File: tb/tb_crypt_job_scheduler.sv
// Directed bench for crypt_job_scheduler; the bench plays both requesters
// and the controller FSM, driving state codes step by step.
module tb_crypt_job_scheduler;

  logic clka = 1'b0;
  logic restart_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  crypt_job_scheduler_if #(.CNT_W(8)) bus ();

  crypt_job_scheduler #(
    .START_TO (4),
    .RUN_TO   (15),
    .CNT_W    (8)
  ) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .bus       (bus.slave)
  );

  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic walk(input logic [2:0] code);
    bus.fsm_state = code;
    tick();
  endtask

  initial begin
    restart_n     = 1'b0;
    bus.req0      = 1'b0;
    bus.req1      = 1'b0;
    bus.mode0     = 1'b0;
    bus.mode1     = 1'b0;
    bus.fsm_state = 3'b000;
    tick();
    tick();

    // Reset state
    chk("rst_gnt0",    bus.gnt0, 0);
    chk("rst_gnt1",    bus.gnt1, 0);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_owner",   bus.owner, 1);
    chk("rst_restart", bus.fsm_restart, 1);
    chk("rst_count",   bus.job_count, 0);
    chk("rst_enable",  bus.fsm_enable, 0);
    chk("rst_encode",  bus.fsm_encode, 0);
    chk("rst_done0",   bus.done0, 0);
    restart_n = 1'b1;
    tick();
    chk("rst_release", bus.fsm_restart, 0);

    // Single encode job on port 0
    bus.req0 = 1'b1;
    bus.mode0 = 1'b1;
    tick();
    chk("se_gnt0",   bus.gnt0, 1);
    chk("se_gnt1",   bus.gnt1, 0);
    chk("se_busy",   bus.busy, 1);
    chk("se_owner",  bus.owner, 0);
    chk("se_en_pre", bus.fsm_enable, 0);
    bus.req0 = 1'b0;
    tick();
    chk("se_gnt_pulse", bus.gnt0, 0);
    chk("se_enable",    bus.fsm_enable, 1);
    chk("se_encode",    bus.fsm_encode, 1);
    tick();
    chk("se_en_once", bus.fsm_enable, 0);
    walk(3'b101);
    walk(3'b110);
    walk(3'b001);
    walk(3'b010);
    walk(3'b011);
    chk("se_enc_hold", bus.fsm_encode, 1);
    chk("se_en_run",   bus.fsm_enable, 0);
    walk(3'b000);
    chk("se_busy_run", bus.busy, 1);
    chk("se_no_done",  bus.done0, 0);
    tick();
    chk("se_done0", bus.done0, 1);
    chk("se_err0",  bus.err0, 0);
    chk("se_done1", bus.done1, 0);
    chk("se_count", bus.job_count, 1);
    chk("se_idle",  bus.busy, 0);
    tick();
    chk("se_done_pulse", bus.done0, 0);

    // Contention from reset: port 0 first, then port 1, then port 0 again
    restart_n = 1'b0;
    tick();
    restart_n = 1'b1;
    tick();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.mode0 = 1'b1;
    bus.mode1 = 1'b0;
    tick();
    chk("ct_gnt0", bus.gnt0, 1);
    chk("ct_gnt1", bus.gnt1, 0);
    bus.req0 = 1'b0;
    tick();
    tick();
    walk(3'b101);
    walk(3'b110);
    walk(3'b001);
    walk(3'b010);
    walk(3'b011);
    walk(3'b000);
    tick();
    chk("ct_done0",  bus.done0, 1);
    chk("ct_err0",   bus.err0, 0);
    chk("ct_count1", bus.job_count, 1);
    chk("ct_no_gnt1_yet", bus.gnt1, 0);
    tick();
    chk("ct_gnt1",  bus.gnt1, 1);
    chk("ct_owner", bus.owner, 1);
    chk("ct_busy",  bus.busy, 1);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.mode0 = 1'b1;
    tick();
    chk("ct_enable1", bus.fsm_enable, 1);
    chk("ct_decode",  bus.fsm_encode, 0);
    tick();
    walk(3'b101);
    walk(3'b110);
    walk(3'b001);
    walk(3'b010);
    walk(3'b100);
    walk(3'b000);
    tick();
    chk("ct_done1",  bus.done1, 1);
    chk("ct_err1",   bus.err1, 0);
    chk("ct_count2", bus.job_count, 2);
    chk("ct_no_gnt_while_done", bus.gnt0, 0);
    tick();
    chk("ct_alt_gnt0", bus.gnt0, 1);
    chk("ct_alt_gnt1", bus.gnt1, 0);
    bus.req0 = 1'b0;

    // Start timeout: FSM stays in IDLE
    tick();
    chk("st_enable", bus.fsm_enable, 1);
    tick();
    tick();
    tick();
    chk("st_no_restart3", bus.fsm_restart, 0);
    chk("st_no_done3",    bus.done0, 0);
    tick();
    chk("st_no_restart4", bus.fsm_restart, 0);
    tick();
    chk("st_restart", bus.fsm_restart, 1);
    chk("st_done0",   bus.done0, 1);
    chk("st_err0",    bus.err0, 1);
    chk("st_busy",    bus.busy, 0);
    chk("st_count",   bus.job_count, 2);

    // Pending req1 granted; mode mismatch (decode job passes through ENC)
    tick();
    chk("mm_gnt1",     bus.gnt1, 1);
    chk("mm_restart",  bus.fsm_restart, 0);
    chk("mm_done0_lo", bus.done0, 0);
    bus.req1 = 1'b0;
    bus.mode1 = 1'b1;
    bus.req0 = 1'b1;
    tick();
    chk("mm_mode_latched", bus.fsm_encode, 0);
    bus.req0 = 1'b0;
    tick();
    walk(3'b101);
    walk(3'b110);
    walk(3'b001);
    walk(3'b010);
    walk(3'b011);
    walk(3'b000);
    tick();
    chk("mm_done1", bus.done1, 1);
    chk("mm_err1",  bus.err1, 1);
    chk("mm_count", bus.job_count, 2);
    tick();
    chk("mm_dropped_req", bus.gnt0, 0);
    chk("mm_idle",        bus.busy, 0);

    // Run timeout: FSM stuck in KG1
    bus.req0 = 1'b1;
    bus.mode0 = 1'b0;
    tick();
    chk("rt_gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    tick();
    tick();
    walk(3'b101);
    bus.fsm_state = 3'b001;
    repeat (14) tick();
    chk("rt_busy14",    bus.busy, 1);
    chk("rt_restart14", bus.fsm_restart, 0);
    tick();
    chk("rt_restart15", bus.fsm_restart, 0);
    chk("rt_done15",    bus.done0, 0);
    tick();
    chk("rt_restart", bus.fsm_restart, 1);
    chk("rt_done0",   bus.done0, 1);
    chk("rt_err0",    bus.err0, 1);
    chk("rt_busy",    bus.busy, 0);
    chk("rt_count",   bus.job_count, 2);
    bus.fsm_state = 3'b000;
    tick();
    chk("rt_restart_pulse", bus.fsm_restart, 0);
    chk("rt_done_pulse",    bus.done0, 0);

    // Reset in the middle of a running job
    bus.req0 = 1'b1;
    bus.mode0 = 1'b1;
    tick();
    chk("mr_gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    tick();
    tick();
    walk(3'b101);
    walk(3'b110);
    restart_n = 1'b0;
    bus.req1 = 1'b1;
    bus.mode1 = 1'b1;
    tick();
    chk("mr_restart", bus.fsm_restart, 1);
    chk("mr_busy",    bus.busy, 0);
    chk("mr_done0",   bus.done0, 0);
    chk("mr_err0",    bus.err0, 0);
    chk("mr_gnt1",    bus.gnt1, 0);
    chk("mr_encode",  bus.fsm_encode, 0);
    chk("mr_enable",  bus.fsm_enable, 0);
    chk("mr_owner",   bus.owner, 1);
    chk("mr_count",   bus.job_count, 0);
    tick();
    chk("mr_done0_hold", bus.done0, 0);
    restart_n = 1'b1;
    bus.fsm_state = 3'b000;
    tick();
    chk("mr_gnt1_after", bus.gnt1, 1);
    chk("mr_release",    bus.fsm_restart, 0);
    bus.req1 = 1'b0;
    tick();
    tick();
    walk(3'b101);
    walk(3'b110);
    walk(3'b001);
    walk(3'b010);
    walk(3'b011);
    walk(3'b000);
    tick();
    chk("mr_done1",  bus.done1, 1);
    chk("mr_err1",   bus.err1, 0);
    chk("mr_count1", bus.job_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/crypt_job_scheduler.md
Name: crypt_job_scheduler

Overview:
- Shares the encode/decode controller FSM between two requesters (port 0, port 1) using round-robin arbitration.
- Launches each job with a one-cycle enable and holds the encode select for the whole job.
- Tracks FSM state codes until the job returns to IDLE, then reports done or error to the owning requester.
- Aborts a hung FSM through its restart input; sits between host-side requesters and the FSM/datapath pair.

Parameters:
- START_TO, default 4: max cycles allowed in WAIT_START for fsm_state to leave IDLE.
- RUN_TO, default 15: max cycles allowed in RUN before abort.
- CNT_W, default 8: width of job_count.

Ports:
- clka  in  1  single system clock; all logic on posedge.
- restart_n  in  1  synchronous, active-low reset.
- req0, req1  in  1  job request; held high until the matching gnt pulse.
- mode0, mode1  in  1  1=encode, 0=decode; sampled in the grant cycle.
- gnt0, gnt1  out  1  one-cycle grant pulse.
- done0, done1  out  1  one-cycle job-complete pulse.
- err0, err1  out  1  pulses together with done on failure.
- fsm_enable  out  1  start pulse to the FSM.
- fsm_encode  out  1  encode select to the FSM.
- fsm_restart  out  1  reset to the FSM.
- fsm_state  in  3  current FSM state code.
- busy  out  1  high from grant through done.
- owner  out  1  index of the current or last granted requester.
- job_count  out  CNT_W  count of successfully completed jobs.

Behaviour:
- Reset (restart_n=0 at a clka edge), all outputs registered:
  - gnt*, done*, err*, fsm_enable, fsm_encode, busy, job_count = 0.
  - owner = 1, so port 0 wins the first contention.
  - fsm_restart = 1 for every cycle restart_n is low; timer and flags cleared.
  - Reset mid-job drops the job silently: no done, no err.
- FSM state codes: IDLE 000, LOAD1 101, LOAD2 110, KG1 001, KG2 010, ENC 011, DEC 100.
- S_IDLE:
  - Any req high: grant to the requester that is not the last owner if both are high, otherwise to the single requester.
  - In the grant cycle: gnt pulse, latch owner and mode, busy=1 from the next cycle, go to S_LAUNCH. Grant latency is 1 cycle after req is sampled.
- S_LAUNCH: fsm_enable=1 for exactly one cycle; fsm_encode=latched mode, held until the job leaves busy; timer cleared; go to S_WAIT_START.
- S_WAIT_START:
  - fsm_state != IDLE: go to S_RUN, timer cleared.
  - Otherwise increment timer; when timer==START_TO-1, go to S_ABORT.
- S_RUN:
  - fsm_state==ENC or DEC: set seen_final; set mismatch if the code disagrees with the latched mode.
  - fsm_state==IDLE: go to S_DONE; if seen_final==0, set mismatch.
  - timer==RUN_TO-1 without IDLE: go to S_ABORT.
- S_DONE:
  - done[owner]=1; err[owner]=mismatch.
  - job_count increments only when mismatch==0; wraps at 2^CNT_W.
  - busy=0 next cycle; go to S_IDLE.
- S_ABORT: fsm_restart=1, done[owner]=1, err[owner]=1, all for one cycle; go to S_IDLE.
- Requests arriving while busy are held pending, not lost; they are arbitrated in the first S_IDLE cycle, giving back-to-back jobs with one idle cycle between them.
- req dropped before grant: no grant. mode changes after grant: ignored.
- fsm_enable is never asserted while busy except in S_LAUNCH.

Decomposition:
- Package crypt_sched_pkg: FSM state-code constants, scheduler state enum (S_IDLE, S_LAUNCH, S_WAIT_START, S_RUN, S_DONE, S_ABORT), MODE_ENC/MODE_DEC constants.
- One sub-module, rr_arbiter2: two requests plus last-owner bit in, one-hot grant out, purely combinational.
- Timer, flags and the main FSM stay in the top level.

Test Plan:
- Single encode: req0=1, mode0=1; FSM model walks 000→101→110→001→010→011→000 → gnt0 one cycle after req, fsm_enable one pulse, fsm_encode=1 throughout, done0=1, err0=0, job_count=1.
- Contention: req0=req1=1 from reset → gnt0 first; req1 granted one cycle after done0; third simultaneous request → gnt0 again (alternates).
- Start timeout, START_TO=4: FSM model stuck at 000 → after 4 WAIT_START cycles fsm_restart=1, done0=err0=1, job_count unchanged.
- Mode mismatch: mode1=0 but model passes through 011 → done1=1, err1=1, job_count unchanged.
- Run timeout: model stuck at 001 for 15 cycles → S_ABORT, fsm_restart pulse, err asserted, busy=0 next cycle.
- Reset mid-job: restart_n=0 during S_RUN → next cycle all outputs 0, fsm_restart=1, no done pulse; after release, req1 is granted normally.
